// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the hazard unit / memory side and pipe_ctrl.
// The slave modport is the controller's view; the master modport is the
// environment that drives the requests and observes the enables.
interface pipe_ctrl_if;

  // Requests into the controller
  logic        hazard_stall;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        halt_in;
  logic        resume;

  // Pipeline register controls out of the controller
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_bubble;

  // Status
  logic        halted;
  logic [2:0]  state;
  logic        stall_err;
  logic [15:0] stall_cycles;

  modport master (
    output hazard_stall,
    output branch_taken,
    output mem_req,
    output mem_ready,
    output halt_in,
    output resume,
    input  pc_en,
    input  if_id_en,
    input  id_ex_en,
    input  ex_mem_en,
    input  mem_wb_en,
    input  if_id_flush,
    input  id_ex_bubble,
    input  halted,
    input  state,
    input  stall_err,
    input  stall_cycles
  );

  modport slave (
    input  hazard_stall,
    input  branch_taken,
    input  mem_req,
    input  mem_ready,
    input  halt_in,
    input  resume,
    output pc_en,
    output if_id_en,
    output id_ex_en,
    output ex_mem_en,
    output mem_wb_en,
    output if_id_flush,
    output id_ex_bubble,
    output halted,
    output state,
    output stall_err,
    output stall_cycles
  );

endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Converts hazard stall, branch redirect, data-memory wait and halt into
// per-stage register enables plus IF/ID flush and ID/EX bubble.
// Optional feature: define PIPE_PERF_EN to build the stall_cycles counter;
// without it stall_cycles is tied to zero.
module pipe_ctrl #(
  parameter int unsigned BRANCH_PENALTY = 2,  // 0..7
  parameter int unsigned MAX_STALL      = 3   // 1..15
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave pipe_io
);

  typedef enum logic [2:0] {
    StRun    = 3'd0,
    StHstall = 3'd1,
    StMwait  = 3'd2,
    StFlush  = 3'd3,
    StHalt   = 3'd4
  } state_e;

  // Remaining FLUSH cycles after the branch cycle itself
  localparam logic [2:0] FlushInit = (BRANCH_PENALTY == 0) ? 3'd0 : 3'(BRANCH_PENALTY - 1);
  localparam logic [3:0] HzMax     = 4'hF;

  state_e     state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic [3:0] hz_cnt_q, hz_cnt_d;
  logic       stall_err_q, stall_err_d;

  logic memstall;
  logic run_like;

  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic mem_wb_en;
  logic if_id_flush;
  logic id_ex_bubble;
  logic halted;

  assign memstall = pipe_io.mem_req & ~pipe_io.mem_ready;

  // MWAIT with the access completing is evaluated exactly like RUN; the
  // frozen EX/MEM means a pending branch_taken is still valid here.
  assign run_like = (state_q == StRun) | (state_q == StHstall) |
                    ((state_q == StMwait) & pipe_io.mem_ready);

  // Next-state, counters and combinational pipeline controls
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    hz_cnt_d     = '0;
    stall_err_d  = stall_err_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = 1'b0;

    if (run_like) begin
      if (memstall) begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        state_d   = StMwait;
      end else if (pipe_io.branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (BRANCH_PENALTY == 0) begin
          state_d = StRun;
        end else begin
          state_d     = StFlush;
          flush_cnt_d = FlushInit;
        end
      end else if (pipe_io.hazard_stall) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        state_d      = StHstall;
        hz_cnt_d     = (hz_cnt_q == HzMax) ? HzMax : hz_cnt_q + 4'd1;
        // Incremented count would exceed the legal stall run
        if (32'(hz_cnt_q) >= MAX_STALL) begin
          stall_err_d = 1'b1;
        end
      end else if (pipe_io.halt_in) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        state_d      = StHalt;
      end else begin
        state_d = StRun;
      end
    end else begin
      unique case (state_q)
        StMwait: begin
          // Access still outstanding: freeze the whole pipe
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end
        StFlush: begin
          // Hazard, halt and a new branch are ignored; EX holds a bubble
          if_id_flush = 1'b1;
          if (memstall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
          end else if (flush_cnt_q == 3'd0) begin
            state_d = StRun;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
        StHalt: begin
          // Front end stopped, back end keeps draining unless memory stalls
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          halted       = 1'b1;
          if (memstall) begin
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
          end else if (pipe_io.resume) begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end

    // Reset overrides all controls so every register loads a NOP
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      halted       = 1'b0;
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
      hz_cnt_q    <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      hz_cnt_q    <= hz_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

`ifdef PIPE_PERF_EN
  logic [15:0] stall_cycles_q;

  // Count front-end stall cycles, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (!pc_en && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign pipe_io.stall_cycles = stall_cycles_q;
`else
  assign pipe_io.stall_cycles = 16'd0;
`endif

  assign pipe_io.pc_en        = pc_en;
  assign pipe_io.if_id_en     = if_id_en;
  assign pipe_io.id_ex_en     = id_ex_en;
  assign pipe_io.ex_mem_en    = ex_mem_en;
  assign pipe_io.mem_wb_en    = mem_wb_en;
  assign pipe_io.if_id_flush  = if_id_flush;
  assign pipe_io.id_ex_bubble = id_ex_bubble;
  assign pipe_io.halted       = halted;
  assign pipe_io.state        = state_q;
  assign pipe_io.stall_err    = stall_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by
// constrained-random stimulus, all compared cycle by cycle against a
// rule-level reference model.
module tb_pipe_ctrl;

  localparam int unsigned BP = 2;
  localparam int unsigned MS = 3;

  localparam int RUN = 0;
  localparam int HST = 1;
  localparam int MW  = 2;
  localparam int FL  = 3;
  localparam int HLT = 4;

  logic clk = 1'b0;
  logic rst;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .BRANCH_PENALTY (BP),
    .MAX_STALL      (MS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pipe_io (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_state = RUN;
  int m_fcnt  = 0;
  int m_hz    = 0;
  bit m_err   = 1'b0;
  int m_perf  = 0;

  int n_state, n_fcnt, n_hz, n_perf;
  bit n_err;

  logic [4:0] e_en;
  bit e_fl, e_bu, e_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit hz, input bit br, input bit mq, input bit mr,
                       input bit ht, input bit rs);
    rst                = r;
    bus.hazard_stall   = hz;
    bus.branch_taken   = br;
    bus.mem_req        = mq;
    bus.mem_ready      = mr;
    bus.halt_in        = ht;
    bus.resume         = rs;
  endtask

  // Expected outputs this cycle and model state after the next edge
  task automatic model_eval();
    bit ms;
    bit run_like;
    ms       = bus.mem_req && !bus.mem_ready;
    e_en     = 5'b11111;
    e_fl     = 1'b0;
    e_bu     = 1'b0;
    e_halt   = 1'b0;
    n_state  = m_state;
    n_fcnt   = m_fcnt;
    n_hz     = 0;
    n_err    = m_err;
    n_perf   = m_perf;
    if (rst) begin
      e_en    = 5'b00000;
      e_fl    = 1'b1;
      e_bu    = 1'b1;
      n_state = RUN;
      n_fcnt  = 0;
      n_err   = 1'b0;
      n_perf  = 0;
    end else begin
      run_like = (m_state == RUN) || (m_state == HST) || (m_state == MW && bus.mem_ready);
      if (run_like) begin
        if (ms) begin
          e_en    = 5'b00000;
          n_state = MW;
        end else if (bus.branch_taken) begin
          e_fl    = 1'b1;
          e_bu    = 1'b1;
          n_state = (BP == 0) ? RUN : FL;
          if (BP != 0) n_fcnt = int'(BP) - 1;
        end else if (bus.hazard_stall) begin
          e_en    = 5'b00111;
          e_bu    = 1'b1;
          n_state = HST;
          n_hz    = m_hz + 1;
          if (n_hz > int'(MS)) n_err = 1'b1;
        end else if (bus.halt_in) begin
          e_en    = 5'b00111;
          e_bu    = 1'b1;
          n_state = HLT;
        end else begin
          n_state = RUN;
        end
      end else if (m_state == MW) begin
        e_en = 5'b00000;
      end else if (m_state == FL) begin
        e_fl = 1'b1;
        if (ms) e_en = 5'b00000;
        else if (m_fcnt == 0) n_state = RUN;
        else n_fcnt = m_fcnt - 1;
      end else begin
        e_halt = 1'b1;
        e_bu   = 1'b1;
        e_en   = ms ? 5'b00000 : 5'b00111;
        if (!ms && bus.resume) n_state = RUN;
      end
      if (!e_en[4] && m_perf < 65535) n_perf = m_perf + 1;
    end
  endtask

  function automatic int exp_perf();
`ifdef PIPE_PERF_EN
    return m_perf;
`else
    return 0;
`endif
  endfunction

  // Check this cycle (inputs already driven), advance model, move to next cycle
  task automatic step();
    #1;
    model_eval();
    chk("enables", {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en},
        e_en);
    chk("if_id_flush", bus.if_id_flush, e_fl);
    chk("id_ex_bubble", bus.id_ex_bubble, e_bu);
    chk("halted", bus.halted, e_halt);
    chk("state", bus.state, m_state);
    chk("stall_err", bus.stall_err, m_err);
    chk("stall_cycles", bus.stall_cycles, exp_perf());
    m_state = n_state;
    m_fcnt  = n_fcnt;
    m_hz    = n_hz;
    m_err   = n_err;
    m_perf  = n_perf;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    bit pend;
    bit r, hz, br, mq, mr, ht, rs;

    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0); step();

    // Two-cycle hazard stall
    drive(0, 1, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 0, 0); step();
    idle(2);

    // Watchdog: four consecutive stalls with MAX_STALL=3
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      step();
    end
    idle(3);
    chk("wd_sticky", bus.stall_err, 1);
    drive(1, 0, 0, 0, 0, 0, 0); step();
    chk("wd_cleared", bus.stall_err, 0);

    // Branch pulse
    drive(0, 0, 1, 0, 0, 0, 0); step();
    idle(3);

    // Memory wait with a pending branch
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0, 0, 0);
      step();
    end
    drive(0, 0, 1, 1, 1, 0, 0); step();
    chk("mw_to_flush", bus.state, FL);
    idle(3);

    // Halt and resume, starting from a cleared perf counter
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0); step();
    chk("halted_next", bus.halted, 1);
    idle(3);
    drive(0, 0, 0, 0, 0, 0, 1); step();
    chk("resume_run", bus.state, RUN);
`ifdef PIPE_PERF_EN
    chk("halt_perf", bus.stall_cycles, 5);
`else
    chk("halt_perf", bus.stall_cycles, 0);
`endif
    idle(1);

    // Memory stall inside FLUSH and inside HALT
    drive(0, 0, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 1, 1, 0, 0); step();
    idle(3);
    drive(0, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 1, 0, 0, 1); step();
    drive(0, 0, 0, 1, 1, 0, 1); step();
    idle(2);

    // Reset mid-FLUSH, then a fresh branch takes the full penalty
    drive(0, 0, 1, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    chk("rst_flush_state", bus.state, RUN);
    drive(0, 0, 1, 0, 0, 0, 0); step();
    idle(3);

    // Constrained-random traffic; mem_req stays up until mem_ready
    pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      hz = ($urandom_range(0, 2) == 0);
      br = ($urandom_range(0, 5) == 0);
      mq = pend || ($urandom_range(0, 3) == 0);
      mr = ($urandom_range(0, 2) == 0);
      ht = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 3) == 0);
      drive(r, hz, br, mq, mr, ht, rs);
      step();
      pend = !r && mq && !mr;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB). It turns the decode-stage hazard stall, the EX-stage branch redirect, the data-memory ready handshake and the decoded halt into per-stage pipeline-register enables, an IF/ID flush and an ID/EX bubble. It sits between the hazard detection unit and the pipeline registers, and is the only block that drives their enables.

## Interface
- BRANCH_PENALTY, 2: extra flush cycles after a taken branch. Legal range 0..7.
- MAX_STALL, 3: longest legal run of consecutive hazard-stall cycles. Legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- hazard_stall  in  1  RAW stall request from hazard detection.
- branch_taken  in  1  EX-stage taken branch or jump; PC loads the target when pc_en=1.
- mem_req  in  1  MEM stage is issuing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- halt_in  in  1  halt opcode decoded in ID.
- resume  in  1  leave the HALT state.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_bubble  out  1  ID/EX loads a NOP.
- halted  out  1  high in HALT.
- state  out  3  RUN=0, HSTALL=1, MWAIT=2, FLUSH=3, HALT=4.
- stall_err  out  1  sticky watchdog flag.
- stall_cycles  out  16  performance counter; see Configuration.

## Operation
Outputs are combinational from the registered state/counters and the current inputs. In the rules below, **memstall** means mem_req & ~mem_ready. Default outputs are all enables 1, flush 0, bubble 0.

Priority in RUN, HSTALL, and MWAIT-with-mem_ready (highest first):
1. **memstall:** all five enables 0. Next state MWAIT.
2. **branch_taken:** all enables 1, if_id_flush=1, id_ex_bubble=1. Next state FLUSH with flush_cnt=BRANCH_PENALTY-1, or RUN if BRANCH_PENALTY=0.
3. **hazard_stall:** pc_en=0, if_id_en=0, id_ex_bubble=1, other enables 1. Next state HSTALL; hz_cnt increments, saturating at 15.
4. **halt_in:** pc_en=0, if_id_en=0, id_ex_bubble=1. Next state HALT.
5. **Otherwise:** defaults. Next state RUN; hz_cnt clears.

State-specific rules:
- **hz_cnt:** clears on any cycle that does not apply rule 3.
- **stall_err:** set when hz_cnt would exceed MAX_STALL. It stays set until rst.
- **MWAIT, mem_ready=0:** all enables 0. Stay in MWAIT.
- **MWAIT, mem_ready=1:** evaluated exactly as RUN. EX/MEM was frozen, so branch_taken is still valid.
- **FLUSH:** defaults plus if_id_flush=1; hazard_stall and halt_in are ignored.
  - memstall in FLUSH: all enables 0, flush_cnt holds, state stays FLUSH.
  - Otherwise flush_cnt decrements. Exit to RUN on the cycle flush_cnt=0.
  - branch_taken in FLUSH is ignored; EX holds a bubble.
- **HALT:** pc_en=0, if_id_en=0, id_ex_bubble=1, later stages enabled so the pipe drains; halted=1.
  - resume=1 leads to RUN next cycle.
  - memstall in HALT freezes all enables; the state stays HALT.

## Timing
- **Reset values** (state after a rst cycle): state RUN, flush_cnt 0, hz_cnt 0, stall_err 0, stall_cycles 0.
- **Outputs while rst=1:** all enables 0, if_id_flush=1, id_ex_bubble=1, halted=0. Reset asserted mid-FLUSH, mid-MWAIT or in HALT behaves identically.
- **Latency:** stall, flush and bubble take effect in the same cycle as the causing input, with zero cycles of added latency. State changes are visible on `state` one cycle later.
- **Taken-branch cost:** 1 + BRANCH_PENALTY cycles with if_id_flush=1.
- **Memory handshake:** mem_req must stay asserted until the cycle mem_ready=1. mem_ready with mem_req=0 is ignored.

## Configuration
- **PIPE_PERF_EN defined:** stall_cycles increments, saturating at 16'hFFFF, on every non-reset cycle with pc_en=0.
- **PIPE_PERF_EN undefined:** stall_cycles is constant 0 and no counter is synthesized.

## Test plan
- **Hazard stall:** hazard_stall high for 2 cycles in RUN -> pc_en=if_id_en=0 and id_ex_bubble=1 for exactly those 2 cycles; state=1 after the first cycle; back to RUN; stall_err=0.
- **Watchdog:** with MAX_STALL=3, hazard_stall held for 4 cycles -> stall_err=1 on the cycle after the 4th and held high until rst.
- **Branch:** branch_taken pulse with BRANCH_PENALTY=2 -> if_id_flush=1 for 3 consecutive cycles, id_ex_bubble=1 in the first only; state 3,3 then 0.
- **Memory wait with pending branch:** mem_req=1, mem_ready=0 for 3 cycles with branch_taken=1 -> all enables 0 for 3 cycles. On the mem_ready cycle the flush/bubble fires and the state goes to FLUSH.
- **Halt:** halt_in -> halted=1 the next cycle, pc_en=0 while halted; resume -> RUN; with PIPE_PERF_EN, stall_cycles equals the cycles spent in HALT plus 1.
- **Reset mid-FLUSH:** rst for 1 cycle with flush_cnt=1 -> enables 0 during rst, state=0 after; the next branch_taken restarts the full penalty.
